sha256_ctrl: RTL
================

Name: sha256_ctrl

Overview:
- Sequencing controller for the SHA-256 compression datapath: IV load, message-schedule load, 64 round steps, digest feed-forward and multi-block chaining.
- Accepts 512-bit blocks through a valid/ready handshake and presents the finished hash through a valid/ready handshake.
- Sits between the host/bus interface and the round datapath. Drives only control strobes; holds no message or hash data.

Parameters:
- ROUNDS, 64, round steps per block; the round counter wraps at ROUNDS-1.
- IDX_W, 6, width of round_idx; must satisfy 2**IDX_W >= ROUNDS.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- blk_valid  in  1  a message block is available at the datapath input.
- blk_first  in  1  qualifies blk_valid: block starts a new message.
- blk_last  in  1  qualifies blk_valid: block ends the message.
- blk_ready  out  1  controller accepts a block this cycle.
- iv_load  out  1  load H0..H7 initial values into the digest registers.
- msg_load  out  1  load the 512-bit block into the schedule window W[0..15].
- work_load  out  1  copy the digest registers into working registers a..h.
- round_en  out  1  execute one round (one W/k step) this cycle.
- round_idx  out  IDX_W  round number for the k-constant select and W mux.
- sched_shift  out  1  advance the schedule window (round_idx >= 16).
- digest_add  out  1  digest[i] <= digest[i] + working[i], mod 2^32.
- hash_valid  out  1  digest holds the final hash.
- hash_ready  in  1  consumer takes the hash.
- ready  out  1  high in IDLE only.
- seq_err  out  1  one-cycle pulse on a chaining violation.

Behaviour:
- Reset values: FSM=IDLE, round_idx=0, chain_open=0, pending_last=0. All outputs 0 except ready=1 and blk_ready=1.
- The FSM has five states: IDLE, LOAD, ROUND, UPDATE, DONE.
- All strobes are Moore outputs except where noted. Each strobe is high for exactly one cycle unless stated otherwise.
- IDLE:
  - blk_ready=ready=1.
  - On blk_valid: latch pending_last=blk_last and go to LOAD.
  - If blk_first=1, or chain_open=0, the next LOAD asserts iv_load.
  - If blk_first=0 and chain_open=0: pulse seq_err in the accept cycle and treat the block as first.
  - If blk_first=1 and chain_open=1: pulse seq_err; the block starts a new message and the old chain is discarded.
- LOAD:
  - Assert msg_load and work_load; also assert iv_load when required.
  - The datapath must apply iv_load before work_load in the same edge (IV forwarded).
  - Clear round_idx and go to ROUND.
- ROUND:
  - round_en=1 and round_idx counts 0..ROUNDS-1, one per cycle.
  - sched_shift=1 when round_idx>=16.
  - At round_idx=ROUNDS-1, go to UPDATE and wrap round_idx to 0.
- UPDATE:
  - Assert digest_add.
  - If pending_last: clear chain_open and go to DONE.
  - Otherwise: set chain_open and go to IDLE.
- DONE:
  - hash_valid=1, held until hash_ready; then go to IDLE.
  - blk_ready=0 in DONE, so a block cannot be accepted in the same cycle as hash handoff.
- Latency:
  - Block accept edge to UPDATE is 1+ROUNDS cycles, i.e. 65.
  - hash_valid rises 66 cycles after the accept edge.
  - Block throughput is ROUNDS+3 cycles when blk_valid is always high and the block is non-last.
- Ignored inputs:
  - blk_valid outside IDLE; blk_first/blk_last without blk_valid.
  - hash_ready outside DONE.
- Reset mid-operation: immediate return to reset values. The partial digest is abandoned and chain_open is cleared.
- round_idx is reported as 0 whenever not in ROUND.

Optional Feature:
- Macro: SHA256_CTRL_ABORT_EN.
- When defined:
  - Add input abort (1 bit).
  - abort=1 in LOAD, ROUND or UPDATE: next state IDLE, chain_open cleared, no digest_add, no hash_valid.
  - abort=1 in DONE: drops hash_valid and returns to IDLE.
  - abort in IDLE has no effect; it has priority over every other transition.
- When undefined: no abort port, and the FSM is as above.

Test Plan:
- Reset release, blk_valid=1, first=1, last=1 at cycle 0 ->
  - iv_load, msg_load and work_load at cycle 1;
  - round_en cycles 2..65 with round_idx 0..63, sched_shift cycles 18..65;
  - digest_add at cycle 66; hash_valid from cycle 67.
  - For "abc", the datapath reports digest ba7816bf...f20015ad.
- Two-block message (first=1,last=0 then first=0,last=1) ->
  - iv_load only on block 1, no seq_err;
  - second accept no earlier than cycle 67;
  - hash_valid after the second UPDATE.
- hash_ready held low 10 cycles in DONE -> hash_valid stays high and blk_ready=0 throughout; blk_valid=1 is ignored until the cycle after hash_ready.
- blk_first=0 with chain_open=0 -> seq_err pulses in the accept cycle and iv_load is asserted.
- reset asserted at round_idx=30 -> outputs return to reset values asynchronously; the next block gets iv_load.
- With SHA256_CTRL_ABORT_EN, abort at round_idx=40 -> IDLE the next cycle, no digest_add, chain_open=0.

Source files
------------

// File: rtl/sha256_ctrl.sv
// SHA-256 compression sequencer: IV/message load, ROUNDS round steps, digest feed-forward, chaining.
// Optional abort input enabled by defining SHA256_CTRL_ABORT_EN.
module sha256_ctrl #(
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned IDX_W  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             blk_valid,
    input  logic             blk_first,
    input  logic             blk_last,
`ifdef SHA256_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             blk_ready,
    output logic             iv_load,
    output logic             msg_load,
    output logic             work_load,
    output logic             round_en,
    output logic [IDX_W-1:0] round_idx,
    output logic             sched_shift,
    output logic             digest_add,
    output logic             hash_valid,
    input  logic             hash_ready,
    output logic             ready,
    output logic             seq_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_UPDATE,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] SCHED_START = IDX_W'(16);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             chain_open_q, chain_open_d;
    logic             pending_last_q, pending_last_d;
    logic             need_iv_q, need_iv_d;
    logic             abort_w;

`ifdef SHA256_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            chain_open_q   <= 1'b0;
            pending_last_q <= 1'b0;
            need_iv_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            chain_open_q   <= chain_open_d;
            pending_last_q <= pending_last_d;
            need_iv_q      <= need_iv_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        chain_open_d   = chain_open_q;
        pending_last_d = pending_last_q;
        need_iv_d      = need_iv_q;
        blk_ready      = 1'b0;
        ready          = 1'b0;
        iv_load        = 1'b0;
        msg_load       = 1'b0;
        work_load      = 1'b0;
        round_en       = 1'b0;
        round_idx      = '0;
        sched_shift    = 1'b0;
        digest_add     = 1'b0;
        hash_valid     = 1'b0;
        seq_err        = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready     = 1'b1;
                blk_ready = 1'b1;
                if (blk_valid) begin
                    pending_last_d = blk_last;
                    need_iv_d      = blk_first | ~chain_open_q;
                    // seq_err is Mealy so it lands in the accept cycle itself
                    seq_err        = blk_first ? chain_open_q : ~chain_open_q;
                    state_d        = S_LOAD;
                end
            end
            S_LOAD: begin
                msg_load  = 1'b1;
                work_load = 1'b1;
                iv_load   = need_iv_q;
                idx_d     = '0;
                state_d   = S_ROUND;
            end
            S_ROUND: begin
                round_en    = 1'b1;
                round_idx   = idx_q;
                sched_shift = (idx_q >= SCHED_START);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_UPDATE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_UPDATE: begin
                digest_add = 1'b1;
                if (pending_last_q) begin
                    chain_open_d = 1'b0;
                    state_d      = S_DONE;
                end else begin
                    chain_open_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_DONE: begin
                hash_valid = 1'b1;
                if (hash_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition and masks the digest/hash strobes.
        if (abort_w && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            idx_d        = '0;
            chain_open_d = 1'b0;
            digest_add   = 1'b0;
            hash_valid   = 1'b0;
        end
    end

endmodule
